// File: rtl/quiz_round_controller_if.sv
// Host/buzzer-side signal bundle for the quiz round controller.
// The master side is the host and buzzer stage; the slave side is the controller.
interface quiz_round_controller_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               arm;
    logic               buzz_a;
    logic               buzz_b;
    logic               tick;
    logic               correct;
    logic               wrong;
    logic               clr_score;
    logic               buzz_en;
    logic               lamp_a;
    logic               lamp_b;
    logic [3:0]         time_left;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               timeout;

    modport master (
        output arm, buzz_a, buzz_b, tick, correct, wrong, clr_score,
        input  buzz_en, lamp_a, lamp_b, time_left, score_a, score_b, timeout
    );

    modport slave (
        input  arm, buzz_a, buzz_b, tick, correct, wrong, clr_score,
        output buzz_en, lamp_a, lamp_b, time_left, score_a, score_b, timeout
    );
endinterface

// File: rtl/quiz_round_controller.sv
// Quiz round controller: arms the buzzer stage, latches the first valid buzz,
// runs the timed answer window, applies the host judgement, keeps scores and
// offers a rebound to the other player after a wrong answer or timeout.
module quiz_round_controller #(
    parameter int unsigned ANSWER_SECS = 5,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic clk,
    input  logic rst,
    quiz_round_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, ANSWER_A, ANSWER_B} state_t;

    localparam logic [3:0]         WINDOW    = 4'(ANSWER_SECS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    state_t             state, state_nx;
    logic               lock_a, lock_b, lock_a_nx, lock_b_nx;
    logic [3:0]         time_left, time_left_nx;
    logic [SCORE_W-1:0] score_a, score_b, score_a_nx, score_b_nx;
    logic               timeout_nx, timeout_q;
    logic               buzz_en_q, lamp_a_q, lamp_b_q;
    logic               fire_a, fire_b;

    // State, lockouts, counters and registered outputs advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lock_a    <= 1'b0;
            lock_b    <= 1'b0;
            time_left <= '0;
            score_a   <= '0;
            score_b   <= '0;
            timeout_q <= 1'b0;
            buzz_en_q <= 1'b0;
            lamp_a_q  <= 1'b0;
            lamp_b_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            lock_a    <= lock_a_nx;
            lock_b    <= lock_b_nx;
            time_left <= time_left_nx;
            score_a   <= score_a_nx;
            score_b   <= score_b_nx;
            timeout_q <= timeout_nx;
            buzz_en_q <= (state_nx == ARMED);
            lamp_a_q  <= (state_nx == ANSWER_A);
            lamp_b_q  <= (state_nx == ANSWER_B);
        end
    end

    // Next-state, lockout, window and score logic with judgement priority correct > wrong > tick.
    always_comb begin
        state_nx     = state;
        lock_a_nx    = lock_a;
        lock_b_nx    = lock_b;
        time_left_nx = time_left;
        score_a_nx   = score_a;
        score_b_nx   = score_b;
        timeout_nx   = 1'b0;
        // A locked player's buzz is masked before the tie check.
        fire_a       = bus.buzz_a & ~lock_a;
        fire_b       = bus.buzz_b & ~lock_b;

        case (state)
            IDLE: begin
                lock_a_nx = 1'b0;
                lock_b_nx = 1'b0;
                if (bus.arm) state_nx = ARMED;
            end
            ARMED: begin
                if (fire_a && !fire_b) begin
                    state_nx     = ANSWER_A;
                    time_left_nx = WINDOW;
                end else if (fire_b && !fire_a) begin
                    state_nx     = ANSWER_B;
                    time_left_nx = WINDOW;
                end
            end
            ANSWER_A, ANSWER_B: begin
                // Leaving the window by any path closes it, so time_left reads 0 afterwards.
                if (bus.correct) begin
                    if (state == ANSWER_A) begin
                        if (score_a != SCORE_MAX) score_a_nx = score_a + SCORE_ONE;
                    end else begin
                        if (score_b != SCORE_MAX) score_b_nx = score_b + SCORE_ONE;
                    end
                    state_nx     = IDLE;
                    time_left_nx = '0;
                end else if (bus.wrong || (bus.tick && time_left == 4'd1)) begin
                    timeout_nx = ~bus.wrong;
                    if (state == ANSWER_A) begin
                        lock_a_nx = 1'b1;
                        state_nx  = lock_b ? IDLE : ARMED;
                    end else begin
                        lock_b_nx = 1'b1;
                        state_nx  = lock_a ? IDLE : ARMED;
                    end
                    time_left_nx = '0;
                end else if (bus.tick) begin
                    time_left_nx = time_left - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (bus.clr_score) begin
            score_a_nx = '0;
            score_b_nx = '0;
        end
    end

    assign bus.buzz_en   = buzz_en_q;
    assign bus.lamp_a    = lamp_a_q;
    assign bus.lamp_b    = lamp_b_q;
    assign bus.time_left = time_left;
    assign bus.score_a   = score_a;
    assign bus.score_b   = score_b;
    assign bus.timeout   = timeout_q;
endmodule
